timer_sequencer: RTL



---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_sequencer_tick_prescaler.sv | 43 ++++
 rtl/timer_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared types and constants for the timer_sequencer block.
//   state_e  : sequencer FSM encoding (IDLE, LOAD, RUN, HOLD, DONE)
//   DIR_DOWN : count from L down to 0
//   DIR_UP   : count from 0 up to L
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage : timer_pkg

// File: rtl/timer_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Free-running divider for the timer sequencer. The internal counter
//   runs 0..prescale while enabled; tick is high in the cycle in which the
//   counter equals prescale, and the counter wraps to 0 on that cycle.
//   Disabling freezes the counter so the phase survives a pause.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (counter -> 0)
//   clr      : synchronous clear, wins over en
//   en       : advance the counter this cycle
//   prescale : divide value P (tick every P+1 enabled cycles)
//   tick     : counter == prescale (combinational, not gated by en)
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = (cnt_q == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : (cnt_q + ONE);
    end
  end

endmodule : tick_prescaler

// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//   Sequences a WIDTH-bit loadable up/down counter through
//   IDLE -> LOAD -> RUN (<-> HOLD) -> DONE, with a prescaler throttling
//   the step rate and optional auto-reload for periodic operation.
//
//   Control inputs are single-cycle requests sampled on the rising edge:
//     start : accepted only in IDLE (and only if stop is low)
//     stop  : from any non-IDLE state return to IDLE, count frozen, no done
//     pause : level; in RUN moves to HOLD, in HOLD keeps the FSM there
//   Priority inside RUN is stop > pause > tick, except that a tick which
//   reaches the terminal value goes to DONE (the counter cannot advance
//   past the terminal value, so there is nothing left to pause).
//
// Build option
//   TIMER_IRQ_EN : adds irq_clr input and sticky irq output (set by done,
//                  set wins over a simultaneous clear).
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   cfg_load     : load value L           (captured on accepted start)
//   cfg_dir      : 0 down L->0, 1 up 0->L (captured on accepted start)
//   cfg_reload   : auto-restart after DONE(captured on accepted start)
//   cfg_prescale : step every P+1 RUN cycles (captured on accepted start)
//   start, stop, pause : control, see above
//   count        : current counter value
//   busy         : state != IDLE
//   done         : high for the single DONE cycle
//   irq_clr, irq : only with TIMER_IRQ_EN
// ---------------------------------------------------------------------------
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      cfg_load,
  input  logic                  cfg_dir,
  input  logic                  cfg_reload,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
`ifdef TIMER_IRQ_EN
  input  logic                  irq_clr,
  output logic                  irq,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]      count_q, count_d;

  // Shadow configuration, only written on an accepted start.
  logic [WIDTH-1:0]      load_q;
  logic                  dir_q;
  logic                  reload_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  capture;

  logic                  pre_clr;
  logic                  pre_en;
  logic                  tick;

  logic [WIDTH-1:0]      start_val;
  logic [WIDTH-1:0]      term_val;
  logic [WIDTH-1:0]      step_val;

  assign start_val = (dir_q == DIR_UP) ? '0 : load_q;
  assign term_val  = (dir_q == DIR_UP) ? load_q : '0;
  assign step_val  = (dir_q == DIR_UP) ? (count_q + ONE) : (count_q - ONE);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pre_clr),
    .en       (pre_en),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // -------------------------------------------------------------------------
  // State, counter and shadow registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= '0;
      dir_q      <= DIR_DOWN;
      reload_q   <= 1'b0;
      prescale_q <= '0;
    end else if (capture) begin
      load_q     <= cfg_load;
      dir_q      <= cfg_dir;
      reload_q   <= cfg_reload;
      prescale_q <= cfg_prescale;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    pre_clr = 1'b0;
    pre_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          count_d = start_val;
          pre_clr = 1'b1;
          state_d = (start_val == term_val) ? DONE : RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          // The pause cycle itself is still a full RUN cycle: the
          // prescaler advances and a pending tick steps the counter.
          pre_en = 1'b1;
          if (tick) begin
            count_d = step_val;
          end
          if (tick && (step_val == term_val)) begin
            state_d = DONE;
          end else if (pause) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = reload_q ? LOAD : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

`ifdef TIMER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule : timer_sequencer
